// File: rtl/exp_pkg.sv
// -----------------------------------------------------------------------------
// exp_pkg
// Shared types and constants for the exp_taylor request scheduler.
//   state_t     : scheduler FSM states
//   id_width()  : width of a requester index for a given requester count
//   N_REQ_DEF   : default number of requesters
//   TIMEOUT_DEF : default watchdog limit in WAIT cycles
// -----------------------------------------------------------------------------
package exp_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping modulo N.
//   req_i   [N]  : request vector
//   ptr_i   [IW] : highest-priority index this cycle (0..N-1)
//   grant_o [N]  : one-hot grant (all zero when no request)
//   idx_o   [IW] : encoded index of the granted request
//   any_o        : at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter
  import exp_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    // Walk the ring starting at the pointer; the first hit wins and later
    // hits are ignored, which keeps the grant one-hot.
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/exp_sched.sv
// -----------------------------------------------------------------------------
// exp_sched
// Shares one external exp_taylor engine among N_REQ requesters. Operands are
// accepted round-robin, sent to the engine with a one-cycle start pulse, and
// the result is returned tagged with the requester index. A watchdog turns a
// hung engine transaction into an error response.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester operand handshake (req_ready one-hot)
//   req_x[N_REQ]        : per-requester operand
//   eng_start           : one-cycle start pulse to the engine
//   eng_x               : engine operand, stable from start until done
//   eng_done            : engine done level (only its rising edge is used)
//   eng_result          : engine result, valid when eng_done rises
//   resp_valid/ready    : response handshake
//   resp_id             : requester index of the response
//   resp_result         : exp(x), or 0.0 on error
//   resp_err            : engine timed out
//   busy                : FSM is not in IDLE
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and its data
// stable until that edge. req_ready is combinational (IDLE only); every other
// output comes straight from a register.
// -----------------------------------------------------------------------------
module exp_sched
  import exp_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ID_W    = id_width(N_REQ),
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  real              req_x [N_REQ],
  output logic             eng_start,
  output real              eng_x,
  input  logic             eng_done,
  input  real              eng_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [ID_W-1:0]  resp_id,
  output real              resp_result,
  output logic             resp_err,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(N_REQ - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q;
  logic              eng_start_q;
  real               eng_x_q;
  logic              resp_valid_q;
  logic [ID_W-1:0]   resp_id_q;
  real               resp_result_q;
  logic              resp_err_q;
  logic              busy_q;

  logic [N_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;

  logic              done_edge;
  logic              grant_fire;
  logic              done_fire;
  logic              tmo_fire;
  logic              resp_fire;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // Only a fresh rise counts; a done level still high from the previous
  // transaction (or a late done after a timeout) is ignored.
  assign done_edge = eng_done & ~done_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    grant_fire = 1'b0;
    done_fire  = 1'b0;
    tmo_fire   = 1'b0;
    resp_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready  = arb_grant;
          grant_fire = 1'b1;
          id_d       = arb_idx;
          ptr_d      = (arb_idx == LAST_ID) ? '0 : arb_idx + 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done_edge) begin
          done_fire = 1'b1;
          state_d   = RESP;
        end else begin
          // Abort on the cycle the incremented count hits TIMEOUT-1, so the
          // error response appears TIMEOUT cycles after the start pulse.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TMO_LAST) begin
            tmo_fire = 1'b1;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_fire = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= '0;
      id_q          <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      eng_start_q   <= 1'b0;
      eng_x_q       <= 0.0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= 0.0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      done_q      <= eng_done;
      eng_start_q <= grant_fire;
      busy_q      <= (state_d != IDLE);
      if (grant_fire) begin
        eng_x_q <= req_x[arb_idx];
      end
      if (done_fire) begin
        resp_result_q <= eng_result;
        resp_err_q    <= 1'b0;
        resp_id_q     <= id_q;
        resp_valid_q  <= 1'b1;
      end else if (tmo_fire) begin
        resp_result_q <= 0.0;
        resp_err_q    <= 1'b1;
        resp_id_q     <= id_q;
        resp_valid_q  <= 1'b1;
      end else if (resp_fire) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign eng_start   = eng_start_q;
  assign eng_x       = eng_x_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_exp_sched.sv
// -----------------------------------------------------------------------------
// tb_exp_sched
// Directed bench for exp_sched with a behavioural exp engine (20-term Taylor
// series, fixed latency, optional hang) and a response scoreboard.
// -----------------------------------------------------------------------------
module tb_exp_sched;

  localparam int N       = 4;
  localparam int ENG_LAT = 5;

  localparam real E_1   = 2.718281828459045;
  localparam real E_M1  = 0.36787944117144233;
  localparam real E_2   = 7.38905609893065;
  localparam real E_05  = 1.6487212707001282;

  typedef struct {
    int  id;
    int  err;
    real res;
    real tol;
  } exp_t;

  // clock / reset / DUT signals
  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  real          req_x [N];
  logic         eng_start;
  real          eng_x;
  logic         eng_done;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  real          resp_result;
  logic         resp_err;
  logic         busy;

  // engine model state
  logic mdl_done;
  logic mdl_busy;
  int   mdl_cnt;
  real  mdl_x;
  real  mdl_result;
  logic eng_hang;
  logic stale_done;

  // bookkeeping
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   grant_cyc = 0;
  int   start_cyc = 0;
  int   done_cyc = 0;
  int   resp_rise_cyc = 0;
  int   start_cnt = 0;
  logic rv_prev = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign eng_done = mdl_done | stale_done;

  exp_sched #(.N_REQ(N), .ID_W(2), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .eng_start   (eng_start),
    .eng_x       (eng_x),
    .eng_done    (eng_done),
    .eng_result  (mdl_result),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  function automatic real taylor(input real x);
    real s;
    real t;
    s = 1.0;
    t = 1.0;
    for (int k = 1; k < 20; k++) begin
      t = t * x / k;
      s = s + t;
    end
    return s;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_real(input string name, input real act, input real exp, input real tol);
    real d;
    checks++;
    d = (act > exp) ? act - exp : exp - act;
    if (!(d <= tol)) begin
      errors++;
      $display("FAIL %s: got %0.9f, expected %0.9f (tol %g)", name, act, exp, tol);
    end
  endtask

  task automatic push_exp(input int id, input real res, input int err, input real tol);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.err = err;
    e.tol = tol;
    exp_q.push_back(e);
  endtask

  // Engine model: drops done on start, raises it ENG_LAT cycles later with
  // the Taylor result and then keeps it high. In hang mode it never raises.
  always @(negedge clk) begin
    if (rst) begin
      mdl_done = 1'b0;
      mdl_busy = 1'b0;
      mdl_cnt  = 0;
    end else if (eng_start) begin
      mdl_done = 1'b0;
      mdl_x    = eng_x;
      mdl_busy = !eng_hang;
      mdl_cnt  = ENG_LAT;
    end else if (mdl_busy) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mdl_result = taylor(mdl_x);
        mdl_done   = 1'b1;
        mdl_busy   = 1'b0;
        done_cyc   = cyc;
      end
    end
  end

  // Monitor + scoreboard: every accepted response is compared with the head
  // of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (eng_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (!rst && resp_valid && !rv_prev) resp_rise_cyc = cyc;
    rv_prev = rst ? 1'b0 : resp_valid;
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got id %0d result %0.9f err %0d, expected none",
                 resp_id, resp_result, resp_err);
      end else begin
        e = exp_q.pop_front();
        check_int("resp_id", int'(resp_id), e.id);
        check_int("resp_err", int'(resp_err), e.err);
        check_real("resp_result", resp_result, e.res, e.tol);
      end
    end
  end

  // Runs cycles until n grants have been made and all responses drained.
  // Granted requesters drop valid unless marked sticky; after the last
  // expected grant every request is withdrawn.
  task automatic serve(input int n, input int exp_g [4], input logic [N-1:0] sticky);
    int got;
    int budget;
    int idx;
    logic [N-1:0] hs;
    got    = 0;
    budget = 0;
    while ((got < n || busy || exp_q.size() != 0) && budget < 2000) begin
      @(negedge clk);
      budget++;
      hs = req_valid & req_ready;
      if (hs != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (hs[i]) idx = i;
        if (got < n) begin
          check_int("grant_order", idx, exp_g[got]);
        end else begin
          checks++;
          errors++;
          $display("FAIL extra_grant: got grant %0d, expected none", idx);
        end
        grant_cyc = cyc;
        got++;
      end
      @(posedge clk);
      #2;
      if (got >= n) req_valid = '0;
      else req_valid = req_valid & ~(hs & ~sticky);
    end
    if (budget >= 2000) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout: got %0d grants, expected %0d", got, n);
    end
  endtask

  task automatic wait_grant(input int i);
    int b;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!req_ready[i] && b < 100);
    check_int("grant_seen", int'(req_ready[i]), 1);
    @(posedge clk);
    #2;
    req_valid[i] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int   s0;
    int   b;
    logic stable;
    logic rr_seen;
    logic [1:0] s_id;
    real  s_res;

    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    eng_hang   = 1'b0;
    stale_done = 1'b0;
    mdl_result = 0.0;
    for (int i = 0; i < N; i++) req_x[i] = 0.0;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    check_int("rst_req_ready", int'(req_ready), 0);
    check_int("rst_eng_start", int'(eng_start), 0);
    check_real("rst_eng_x", eng_x, 0.0, 0.0);
    check_int("rst_resp_valid", int'(resp_valid), 0);
    check_int("rst_resp_id", int'(resp_id), 0);
    check_real("rst_resp_result", resp_result, 0.0, 0.0);
    check_int("rst_resp_err", int'(resp_err), 0);
    check_int("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // single request
    s0 = start_cnt;
    req_x[0]     = 1.0;
    req_valid[0] = 1'b1;
    push_exp(0, E_1, 0, 1e-9);
    serve(1, '{0, 0, 0, 0}, 4'b0000);
    check_int("start_pulses", start_cnt - s0, 1);
    check_int("grant_to_start", start_cyc - grant_cyc, 1);
    check_int("done_to_resp", resp_rise_cyc - done_cyc, 1);

    // all four at once from pointer 0
    pulse_reset();
    req_x[0] = 0.0;
    req_x[1] = 1.0;
    req_x[2] = -1.0;
    req_x[3] = 2.0;
    req_valid = 4'b1111;
    push_exp(0, 1.0, 0, 1e-6);
    push_exp(1, E_1, 0, 1e-6);
    push_exp(2, E_M1, 0, 1e-6);
    push_exp(3, E_2, 0, 1e-6);
    serve(4, '{0, 1, 2, 3}, 4'b0000);

    // pointer wrapped back to 0: req0 beats req3
    req_x[0] = 2.0;
    req_x[3] = 0.0;
    req_valid = 4'b1001;
    push_exp(0, E_2, 0, 1e-6);
    push_exp(3, 1.0, 0, 1e-6);
    serve(2, '{0, 3, 0, 0}, 4'b0000);

    // fairness between two continuously valid requesters
    req_x[2] = 1.0;
    req_x[3] = -1.0;
    req_valid = 4'b1100;
    push_exp(2, E_1, 0, 1e-6);
    push_exp(3, E_M1, 0, 1e-6);
    push_exp(2, E_1, 0, 1e-6);
    push_exp(3, E_M1, 0, 1e-6);
    serve(4, '{2, 3, 2, 3}, 4'b1100);

    // backpressure on the response channel
    resp_ready   = 1'b0;
    req_x[1]     = 0.5;
    req_valid[1] = 1'b1;
    push_exp(1, E_05, 0, 1e-6);
    wait_grant(1);
    req_x[0]     = -1.0;
    req_valid[0] = 1'b1;
    push_exp(0, E_M1, 0, 1e-6);
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!resp_valid && b < 200);
    check_int("bp_resp_valid", int'(resp_valid), 1);
    s_id    = resp_id;
    s_res   = resp_result;
    s0      = start_cnt;
    stable  = 1'b1;
    rr_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!resp_valid || resp_id != s_id || resp_result != s_res) stable = 1'b0;
      if (req_ready != '0) rr_seen = 1'b1;
    end
    check_int("bp_stable", int'(stable), 1);
    check_int("bp_no_req_ready", int'(rr_seen), 0);
    check_int("bp_no_start", start_cnt - s0, 0);
    @(posedge clk);
    #2;
    resp_ready = 1'b1;
    serve(1, '{0, 0, 0, 0}, 4'b0000);

    // watchdog: engine never answers
    eng_hang     = 1'b1;
    req_x[2]     = 1.0;
    req_valid[2] = 1'b1;
    push_exp(2, 0.0, 1, 0.0);
    serve(1, '{2, 0, 0, 0}, 4'b0000);
    check_int("timeout_latency", resp_rise_cyc - start_cyc, 64);

    // watchdog with a stale done level held high through the transaction
    stale_done   = 1'b1;
    req_x[3]     = 1.0;
    req_valid[3] = 1'b1;
    push_exp(3, 0.0, 1, 0.0);
    serve(1, '{3, 0, 0, 0}, 4'b0000);
    check_int("stale_timeout_latency", resp_rise_cyc - start_cyc, 64);
    stale_done = 1'b0;

    // reset while waiting on the engine: no response may follow
    req_x[0]     = 0.3;
    req_valid[0] = 1'b1;
    wait_grant(0);
    repeat (10) @(posedge clk);
    #2;
    check_int("wait_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_int("midrst_resp_valid", int'(resp_valid), 0);
    check_int("midrst_busy", int'(busy), 0);
    check_int("midrst_eng_start", int'(eng_start), 0);
    check_real("midrst_eng_x", eng_x, 0.0, 0.0);
    repeat (2) @(posedge clk);
    #2;
    rst      = 1'b0;
    eng_hang = 1'b0;
    req_x[1]     = 0.5;
    req_valid[1] = 1'b1;
    push_exp(1, E_05, 0, 1e-6);
    serve(1, '{1, 0, 0, 0}, 4'b0000);

    repeat (5) @(posedge clk);
    check_int("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exp_sched.md
Name: exp_sched

Overview:
- Round-robin controller that shares one exp_taylor engine among N_REQ requesters.
- Accepts one real operand per requester over valid/ready and sequences the engine's start/done protocol.
- Returns each result tagged with the originating requester ID over a valid/ready response channel.
- Has a watchdog that aborts a hung engine transaction.
- Sits between the requester-side datapath blocks and a single exp_taylor instance, which is outside this block.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), width of requester ID.
- TIMEOUT, 64, maximum cycles in WAIT before abort (must exceed N_TERMS+3 of the engine).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_x  in  real[N_REQ]  per-requester operand.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_x  out  real  operand to the engine; held stable from the start pulse until done.
- eng_done  in  1  engine done, level signal; rises once per computation and may stay high afterwards.
- eng_result  in  real  engine result, valid when eng_done rises.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  requester index of the response.
- resp_result  out  real  exp(x), or 0.0 on error.
- resp_err  out  1  1 = engine timed out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_ready=0, eng_start=0, eng_x=0.0, resp_valid=0, resp_id=0, resp_result=0.0, resp_err=0, busy=0. Round-robin pointer=0, timeout counter=0, done_q=0, state=IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the arbiter picks the first requester at or after the pointer, wrapping modulo N_REQ.
  - req_ready[g] is driven combinationally high in that same cycle, so the handshake completes in one cycle.
  - Latch req_x[g] into eng_x and g into the internal ID, then go to ISSUE.
  - If no req_valid is high, stay in IDLE with all req_ready=0.
- Pointer update: on grant, the pointer becomes g+1 mod N_REQ.
- ISSUE: eng_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Detect the rising edge only, eng_done & ~done_q, where done_q is eng_done registered every cycle. A done level left over from the previous transaction is ignored.
  - On the edge: resp_result<=eng_result, resp_err<=0, resp_id<=ID, resp_valid<=1, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no edge: resp_result<=0.0, resp_err<=1, resp_valid<=1, go to RESP.
  - A late engine done is later masked by the edge rule.
- RESP:
  - Hold resp_* stable while resp_ready=0.
  - When resp_valid & resp_ready: resp_valid<=0, go to IDLE.
  - No new grant is made in this cycle.
- Latency:
  - Grant to eng_start is 1 cycle.
  - Engine done edge to resp_valid is 1 cycle.
  - Back-to-back service requires a minimum of 1 IDLE cycle between transactions.
- Simultaneous events:
  - Requests arriving during ISSUE/WAIT/RESP wait; req_ready stays 0.
  - A requester that drops req_valid before its grant loses its turn.
- Reset mid-operation:
  - All outputs return to reset values immediately, including an in-flight transaction; no response is issued.
  - The engine shares rst, so no abort signalling is needed.
- Outputs other than req_ready are registered.

Decomposition:
- exp_pkg holds:
  - the state_t enum {IDLE, ISSUE, WAIT, RESP};
  - a localparam function for ID_W;
  - default constants N_REQ_DEF=4 and TIMEOUT_DEF=64.
- One sub-module, rr_arbiter #(N):
  - inputs: req vector and pointer;
  - outputs: one-hot grant, encoded index, any_grant;
  - purely combinational.
- exp_sched holds the FSM, latches, watchdog and response register.

Test Plan:
- Single request, req0 x=1.0 with real exp_taylor N_TERMS=20 -> one eng_start pulse; resp_id=0; |resp_result-2.718281828| < 1e-9; resp_err=0.
- All four requests together with x=0.0, 1.0, -1.0, 2.0 held valid -> service order 0,1,2,3; results 1.0, 2.71828, 0.36788, 7.38906 (tol 1e-6); pointer then back to 0.
- Fairness: req2 and req3 continuously valid after req2 served -> next grant is req3, then req2, alternating.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_id and resp_result stable; no req_ready and no eng_start until the handshake completes.
- Timeout: engine model never raises eng_done, TIMEOUT=64 -> resp_valid exactly 64 cycles after eng_start; resp_err=1; resp_result=0.0. A stale eng_done already held high at issue is also ignored.
- Reset asserted in WAIT -> same-cycle resp_valid=0 and busy=0. After release, a new req1 x=0.5 -> resp_result 1.648721 ± 1e-6, resp_id=1.
